// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its stall/flush sequencer.
// master = pipeline side (reports hazards, consumes enables); slave = sequencer.
interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_access;
  logic       dmem_ready;
  logic       dmem_req;
  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_bubble;
  logic       mem_fault;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    input  dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    output dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_fault
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch flushes, dmem waits with timeout abort.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DMEM_TIMEOUT - 1);

  typedef enum logic {
    RUN       = 1'b0,
    DMEM_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;

  logic load_use_c;
  logic eval_front_c;
  logic dmem_req_c, pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
  logic if_id_flush_c, id_ex_flush_c, mem_wb_bubble_c, mem_fault_c;

  // State and wait-counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  assign load_use_c = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Next state and pipeline controls; the front end is only evaluated when MEM is not frozen
  always_comb begin
    state_nxt       = state;
    wcnt_nxt        = wcnt;
    eval_front_c    = 1'b0;
    dmem_req_c      = 1'b0;
    pc_en_c         = 1'b0;
    if_id_en_c      = 1'b0;
    id_ex_en_c      = 1'b0;
    ex_mem_en_c     = 1'b0;
    mem_wb_en_c     = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    mem_wb_bubble_c = 1'b0;
    mem_fault_c     = 1'b0;

    case (state)
      RUN: begin
        dmem_req_c = hz.mem_access;
        if (hz.mem_access && !hz.dmem_ready) begin
          mem_wb_en_c     = 1'b1;
          mem_wb_bubble_c = 1'b1;
          state_nxt       = DMEM_WAIT;
          wcnt_nxt        = WCNT_W'(1);
        end else begin
          eval_front_c = 1'b1;
        end
      end
      DMEM_WAIT: begin
        dmem_req_c = 1'b1;
        if (hz.dmem_ready) begin
          eval_front_c = 1'b1;
          state_nxt    = RUN;
          wcnt_nxt     = '0;
        end else if (wcnt == WCNT_LAST) begin
          // Access abandoned: release the pipeline, MEM/WB takes a bubble
          mem_fault_c     = 1'b1;
          mem_wb_bubble_c = 1'b1;
          eval_front_c    = 1'b1;
          state_nxt       = RUN;
          wcnt_nxt        = '0;
        end else begin
          mem_wb_en_c     = 1'b1;
          mem_wb_bubble_c = 1'b1;
          wcnt_nxt        = wcnt + WCNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase

    if (eval_front_c) begin
      pc_en_c     = 1'b1;
      if_id_en_c  = 1'b1;
      id_ex_en_c  = 1'b1;
      ex_mem_en_c = 1'b1;
      mem_wb_en_c = 1'b1;
      if (hz.ex_branch_taken) begin
        if_id_flush_c = 1'b1;
        id_ex_flush_c = 1'b1;
      end else if (load_use_c) begin
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        id_ex_flush_c = 1'b1;
      end
    end
  end

  // Reset forces every control low immediately, including an in-flight dmem request
  assign hz.dmem_req      = rstn & dmem_req_c;
  assign hz.pc_en         = rstn & pc_en_c;
  assign hz.if_id_en      = rstn & if_id_en_c;
  assign hz.id_ex_en      = rstn & id_ex_en_c;
  assign hz.ex_mem_en     = rstn & ex_mem_en_c;
  assign hz.mem_wb_en     = rstn & mem_wb_en_c;
  assign hz.if_id_flush   = rstn & if_id_flush_c;
  assign hz.id_ex_flush   = rstn & id_ex_flush_c;
  assign hz.mem_wb_bubble = rstn & mem_wb_bubble_c;
  assign hz.mem_fault     = rstn & mem_fault_c;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating perf counters: stalled-PC cycles and branch-flush cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en_c && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush_c && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized self-checking bench for pipeline_hazard_ctrl against a request-count reference model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned TO    = 4;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rstn;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  pipeline_hazard_ctrl_if hz();

  pipeline_hazard_ctrl #(.DMEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: number of request cycles already spent on the current dmem access
  int          m_reqs  = 0;
  longint      m_stall = 0;
  longint      m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, hz.dmem_req, hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
            hz.mem_wb_en, hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_bubble, hz.mem_fault};
  endfunction

  function automatic logic [31:0] exp_cnt(input longint v);
`ifdef HAZARD_PERF_CNT_EN
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br, input logic ma,
                       input logic rdy);
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
    hz.ex_rd = rd; hz.ex_mem_read = mr; hz.ex_branch_taken = br;
    hz.mem_access = ma; hz.dmem_ready = rdy;
  endtask

  // One cycle: drive, check against the model mid-cycle, advance the model at the edge
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic ma, input logic rdy);
    bit req, frozen, fault, lu, pc, ifid, idex, exmem, memwb, ff_if, ff_id, bub;
    drive(rs1, rs2, u1, u2, rd, mr, br, ma, rdy);
    @(negedge clk);
    req    = (m_reqs > 0) || ma;
    fault  = (m_reqs > 0) && !rdy && (m_reqs + 1 == TO);
    frozen = req && !rdy && !fault;
    lu     = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    bub    = frozen || fault;
    memwb  = 1'b1;
    {pc, ifid, idex, exmem, ff_if, ff_id} = 6'b000000;
    if (!frozen) begin
      {pc, ifid, idex, exmem} = 4'b1111;
      if (br) begin
        ff_if = 1'b1; ff_id = 1'b1;
      end else if (lu) begin
        pc = 1'b0; ifid = 1'b0; ff_id = 1'b1;
      end
    end
    check({tag, "_outs"}, outs(),
          {22'd0, req, pc, ifid, idex, exmem, memwb, ff_if, ff_id, bub, fault});
    check({tag, "_stall"}, stall_cycles, exp_cnt(m_stall));
    check({tag, "_flush"}, flush_count, exp_cnt(m_flush));
    @(posedge clk);
    m_reqs = frozen ? m_reqs + 1 : 0;
    if (!pc) m_stall++;
    if (ff_if) m_flush++;
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    m_reqs = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_outs", outs(), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_flush", flush_count, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("rel_pc_en", 32'(hz.pc_en), 32'd1);

    // Perf scenario: two load-use stalls, a 3-cycle dmem wait, one branch
    step("lu1", 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("n1");
    step("lu_rd0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu2", 5'd7, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("dw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("dw_rel", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("br", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("n2");
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", stall_cycles, 32'd5);
    check("perf_flush", flush_count, 32'd1);
`else
    check("perf_stall", stall_cycles, 32'd0);
    check("perf_flush", flush_count, 32'd0);
`endif

    // Timeout with ready held low, then normal run
    for (int i = 0; i < int'(TO); i++)
      step("to", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle("to_after");

    // Priority: branch beats load-use; dmem stall beats both, flush deferred to release
    step("pri_br_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step("pri_dm", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("pri_dm2", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("pri_rel", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a wait drops dmem_req at once
    step("mw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw2", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rstn = 1'b0;
    #1 check("mw_rst_req", 32'(hz.dmem_req), 32'd0);
    do_reset();
    idle("mw_after");

    // Random traffic biased toward register matches and short waits
    for (int i = 0; i < 2000; i++) begin
      logic [4:0] rs1, rs2, rd;
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      step("rnd", rs1, rs2, 1'($urandom), 1'($urandom), rd, 1'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
